// File: rtl/rect_grab_sched.sv
// Mouse-ownership arbiter for a set of falling-rectangle controllers.
// Also generates the shared physics tick. On a left-button press it hit-tests the objects in priority order.
module rect_grab_sched #(
    parameter int N_OBJ    = 4,
    parameter int RECT_W   = 48,
    parameter int RECT_H   = 64,
    parameter int TICK_DIV = 650000
) (
    input  logic                       clk65MHz,
    input  logic                       rst,
    input  logic                       mouse_left,
    input  logic [11:0]                mouse_xpos,
    input  logic [11:0]                mouse_ypos,
    input  logic [12*N_OBJ-1:0]        obj_xpos,
    input  logic [12*N_OBJ-1:0]        obj_ypos,
    input  logic [N_OBJ-1:0]           obj_busy,
    output logic                       tick,
    output logic [N_OBJ-1:0]           grant,
    output logic [$clog2(N_OBJ)-1:0]   grant_idx,
    output logic                       release_p
);

    localparam int IW = $clog2(N_OBJ);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0]    C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    C_CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    C_CNT_PRE  = CW'(TICK_DIV - 2);
    localparam logic [IW-1:0]    C_IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]    C_IDX_LAST = IW'(N_OBJ - 1);
    localparam logic [N_OBJ-1:0] C_ONE_HOT  = {{(N_OBJ-1){1'b0}}, 1'b1};
    localparam logic [12:0]      C_RECT_W   = 13'(RECT_W);
    localparam logic [12:0]      C_RECT_H   = 13'(RECT_H);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SCAN     = 2'd1,
        S_HELD     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_tick;
    logic               r_mouse_left_d;
    logic [11:0]        r_mx;
    logic [11:0]        r_my;
    logic [11:0]        w_mx_nxt;
    logic [11:0]        w_my_nxt;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      w_idx_nxt;
    logic [N_OBJ-1:0]   r_grant;
    logic [N_OBJ-1:0]   w_grant_nxt;
    logic [IW-1:0]      r_grant_idx;
    logic [IW-1:0]      w_grant_idx_nxt;
    logic               r_release;
    logic               w_release_nxt;
    logic               w_press;
    logic               w_hit;
    logic [11:0]        w_ox;
    logic [11:0]        w_oy;

    assign w_press = mouse_left & ~r_mouse_left_d;

    // Free-running tick divider; tick is registered one count early so it lands on the last count.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == C_CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
            r_tick <= (r_cnt == C_CNT_PRE);
        end
    end

    // Hit test for the object currently under scan; 13-bit compares keep the right/bottom edges from wrapping.
    always_comb begin
        w_ox  = obj_xpos[32'(r_idx) * 32'd12 +: 12];
        w_oy  = obj_ypos[32'(r_idx) * 32'd12 +: 12];
        w_hit = ~obj_busy[r_idx]
              & ({1'b0, r_mx} >= {1'b0, w_ox})
              & ({1'b0, r_mx} <  ({1'b0, w_ox} + C_RECT_W))
              & ({1'b0, r_my} >= {1'b0, w_oy})
              & ({1'b0, r_my} <  ({1'b0, w_oy} + C_RECT_H));
    end

    // Scheduler next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_mx_nxt        = r_mx;
        w_my_nxt        = r_my;
        w_idx_nxt       = r_idx;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_release_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // grant_idx survives the release_p cycle, then falls to zero here
                w_grant_nxt     = '0;
                w_grant_idx_nxt = '0;
                if (w_press) begin
                    w_mx_nxt    = mouse_xpos;
                    w_my_nxt    = mouse_ypos;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!mouse_left) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_grant_nxt     = C_ONE_HOT << r_idx;
                    w_grant_idx_nxt = r_idx;
                    w_state_nxt     = S_HELD;
                end else if (r_idx == C_IDX_LAST) begin
                    w_state_nxt = S_WAIT_REL;
                end else begin
                    w_idx_nxt = r_idx + C_IDX_ONE;
                end
            end
            S_HELD: begin
                if (!mouse_left) begin
                    w_grant_nxt   = '0;
                    w_release_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_state_nxt = S_HELD;
                end
            end
            S_WAIT_REL: begin
                if (!mouse_left) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_REL;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_grant_nxt     = '0;
                w_grant_idx_nxt = '0;
            end
        endcase
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mouse_left_d <= 1'b0;
            r_mx           <= '0;
            r_my           <= '0;
            r_idx          <= '0;
            r_grant        <= '0;
            r_grant_idx    <= '0;
            r_release      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mouse_left_d <= mouse_left;
            r_mx           <= w_mx_nxt;
            r_my           <= w_my_nxt;
            r_idx          <= w_idx_nxt;
            r_grant        <= w_grant_nxt;
            r_grant_idx    <= w_grant_idx_nxt;
            r_release      <= w_release_nxt;
        end
    end

    assign tick      = r_tick;
    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign release_p = r_release;

endmodule

// File: tb/tb_rect_grab_sched.sv
// Scoreboard bench for rect_grab_sched: stimulus queues expected output events,
// a monitor compares every change of the grant outputs and every tick against them.
module tb_rect_grab_sched;

    localparam int TD = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ml  = 1'b0;
    logic [11:0] mx  = 12'd0;
    logic [11:0] my  = 12'd0;
    logic [47:0] ox;
    logic [47:0] oy;
    logic [3:0]  busy = 4'b0000;
    logic        tick;
    logic [3:0]  grant;
    logic [1:0]  gidx;
    logic        rel;

    rect_grab_sched #(
        .N_OBJ(4), .RECT_W(48), .RECT_H(64), .TICK_DIV(TD)
    ) dut (
        .clk65MHz  (clk),
        .rst       (rst),
        .mouse_left(ml),
        .mouse_xpos(mx),
        .mouse_ypos(my),
        .obj_xpos  (ox),
        .obj_ypos  (oy),
        .obj_busy  (busy),
        .tick      (tick),
        .grant     (grant),
        .grant_idx (gidx),
        .release_p (rel)
    );

    always #5 clk = ~clk;

    // cycle number: 0 is the first cycle after the last reset edge
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
    } ev_t;

    ev_t  exp_q[$];
    int   tick_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    endtask

    task automatic miss(input string nm, input int c);
        chk_cnt++;
        $display("FAIL %s: expected event at cycle %0d never seen", nm, c);
    endtask

    task automatic expect_ev(input int c, input logic [3:0] g, input logic [1:0] i, input logic r);
        ev_t e;
        e.c = c;
        e.v = {g, i, r};
        exp_q.push_back(e);
    endtask

    task automatic arm_ticks();
        tick_q.delete();
        for (int m = 0; m < 400; m++) tick_q.push_back(TD - 1 + m * TD);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_obj(input int i, input int x, input int y);
        ox[12*i +: 12] = 12'(x);
        oy[12*i +: 12] = 12'(y);
    endtask

    task automatic park();
        for (int i = 0; i < 4; i++) set_obj(i, 3000 + 100 * i, 3000);
    endtask

    task automatic press(input int x, input int y, output int t);
        mx = 12'(x);
        my = 12'(y);
        ml = 1'b1;
        t  = cyc;
    endtask

    // release after a grant on object i: one release_p cycle, then grant_idx drops to 0
    task automatic release_grant(input logic [1:0] i);
        int c;
        ml = 1'b0;
        c  = cyc;
        expect_ev(c + 1, 4'b0000, i, 1'b1);
        expect_ev(c + 2, 4'b0000, 2'd0, 1'b0);
        step(4);
    endtask

    task automatic release_quiet();
        ml = 1'b0;
        step(4);
    endtask

    // monitor: sample just after the active edge
    initial begin : monitor
        logic [6:0] prev;
        logic [6:0] cur;
        ev_t        e;
        prev = 7'd0;
        forever begin
            @(posedge clk);
            #1;
            if (tick) begin
                if (tick_q.size() == 0) chk("tick_unexpected", cyc, -1);
                else chk("tick_cycle", cyc, tick_q.pop_front());
            end
            cur = {grant, gidx, rel};
            if (cur != prev) begin
                if (exp_q.size() == 0) begin
                    chk("event_unexpected", int'(cur), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc, e.c);
                    chk("event_value", int'(cur), int'(e.v));
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        ev_t e;
        ox = '0;
        oy = '0;
        park();
        arm_ticks();
        step(3);
        rst = 1'b0;
        // reset state, cycle 0
        chk("reset_grant", int'(grant), 0);
        chk("reset_gidx", int'(gidx), 0);
        chk("reset_release", int'(rel), 0);
        chk("reset_tick", int'(tick), 0);

        // three tick periods with nothing else happening
        step(3 * TD + 2);

        // obj2 hit, press coincides with a tick cycle
        set_obj(2, 100, 200);
        while ((cyc % TD) != TD - 1) step(1);
        press(120, 230, t);
        expect_ev(t + 4, 4'b0100, 2'd2, 1'b0);
        step(8);
        release_grant(2'd2);

        // overlap: lower index wins
        park();
        set_obj(1, 300, 300);
        set_obj(3, 300, 300);
        press(310, 310, t);
        expect_ev(t + 3, 4'b0010, 2'd1, 1'b0);
        step(6);
        release_grant(2'd1);

        // rectangle edges: last pixel inside, first pixel outside
        park();
        set_obj(0, 500, 500);
        press(547, 563, t);
        expect_ev(t + 2, 4'b0001, 2'd0, 1'b0);
        step(5);
        release_grant(2'd0);
        press(548, 500, t);
        step(8);
        release_quiet();
        press(547, 564, t);
        step(8);
        release_quiet();

        // no wrap at the screen corner
        park();
        set_obj(3, 4090, 4090);
        press(4095, 4095, t);
        expect_ev(t + 5, 4'b1000, 2'd3, 1'b0);
        step(6);
        release_grant(2'd3);

        // empty press: WAIT_REL never rescans even when an object moves under the mouse
        park();
        press(1000, 10, t);
        step(10);
        set_obj(0, 990, 0);
        step(1000);
        release_quiet();
        press(1000, 10, t);
        expect_ev(t + 2, 4'b0001, 2'd0, 1'b0);
        step(5);
        release_grant(2'd0);

        // busy object skipped; busy/position changes during HELD ignored
        park();
        busy = 4'b0001;
        set_obj(0, 600, 600);
        press(610, 610, t);
        step(8);
        release_quiet();
        set_obj(1, 600, 600);
        press(610, 610, t);
        expect_ev(t + 3, 4'b0010, 2'd1, 1'b0);
        step(3);
        busy = 4'b0000;
        set_obj(1, 3000, 3000);
        step(10);
        release_grant(2'd1);

        // button dropped mid-scan: no grant, no release_p
        park();
        set_obj(3, 700, 700);
        press(710, 710, t);
        step(2);
        ml = 1'b0;
        step(10);

        // reset while grant=1000: drop grant, no release_p, tick phase restarts
        press(710, 710, t);
        expect_ev(t + 5, 4'b1000, 2'd3, 1'b0);
        step(8);
        rst = 1'b1;
        ml  = 1'b0;
        arm_ticks();
        expect_ev(0, 4'b0000, 2'd0, 1'b0);
        step(1);
        rst = 1'b0;
        step(2 * TD + 3);

        // leftovers
        step(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            miss("event_missing", e.c);
        end
        while (tick_q.size() > 0 && tick_q[0] <= cyc) miss("tick_missing", tick_q.pop_front());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
